// File: rtl/mod_acc_stage.sv
// rtl/mod_acc_stage.sv - Modular frame accumulator: sums N products mod Q, holds result for handshake
// Optional feature macro: MOD_ACC_RANGECHK_EN (pre-reduce out-of-range beats, sticky err flag)
module mod_acc_stage #(
  parameter int             V = 16,
  parameter logic [2*V-1:0] Q = 32'd4294955009,
  parameter int             N = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*V-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*V-1:0] out_data,
  output logic           err
);

  localparam int            W    = 2 * V;
  localparam int            CW   = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [W:0]    QX   = {1'b0, Q};

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state, state_nx;
  logic [W-1:0]  acc, acc_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [W-1:0]  out_q, out_nx;
  logic [W-1:0]  x;
  logic [W:0]    s;
  logic [W-1:0]  red;
  logic          accept;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);
  assign out_data  = out_q;

  // clr takes priority over a same-cycle beat
  assign accept = (state == ACC) && in_valid && !clr;

`ifdef MOD_ACC_RANGECHK_EN
  logic range_hit;
  logic err_q;

  assign range_hit = (in_data >= Q);
  assign x         = range_hit ? (in_data - Q) : in_data;
  assign err       = err_q;

  // Sticky range error: only reset clears it, clr deliberately leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept && range_hit) begin
      err_q <= 1'b1;
    end
  end
`else
  assign x   = in_data;
  assign err = 1'b0;
`endif

  // One conditional subtract keeps the sum in [0, Q) since both operands are < Q
  assign s   = {1'b0, acc} + {1'b0, x};
  assign red = (s >= QX) ? W'(s - QX) : s[W-1:0];

  // Next-state: accumulate in ACC, close the frame on the N-th beat, wait in HOLD
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    out_nx   = out_q;
    case (state)
      ACC: begin
        if (clr) begin
          acc_nx = '0;
          cnt_nx = '0;
        end else if (in_valid) begin
          if (cnt == LAST) begin
            out_nx   = red;
            acc_nx   = '0;
            cnt_nx   = '0;
            state_nx = HOLD;
          end else begin
            acc_nx = red;
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      HOLD: begin
        if (clr || out_ready) begin
          state_nx = ACC;
        end
      end
      default: state_nx = ACC;
    endcase
  end

  // State register; reset drops any partial frame and any held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
      out_q <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      out_q <= out_nx;
    end
  end

endmodule

// File: tb/tb_mod_acc_stage.sv
// tb/tb_mod_acc_stage.sv - Self-checking bench for mod_acc_stage with a frame-level reference model
module tb_mod_acc_stage;

  localparam int    V  = 16;
  localparam int    N  = 4;
  localparam longint QL = 64'd4294955009;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        err;

  int errors = 0;
  int checks = 0;

  mod_acc_stage #(.V(V), .Q(32'd4294955009), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: running sum mod Q over a beat count, result held until taken
  bit     m_hold = 0;
  longint m_sum  = 0;
  int     m_cnt  = 0;
  longint m_out  = 0;
  bit     m_err  = 0;

  always @(posedge clk or negedge rst_n) begin
    longint xv;
    if (!rst_n) begin
      m_hold = 0; m_sum = 0; m_cnt = 0; m_out = 0; m_err = 0;
    end else if (m_hold) begin
      if (clr || out_ready) m_hold = 0;
    end else if (clr) begin
      m_sum = 0; m_cnt = 0;
    end else if (in_valid) begin
      xv = longint'(in_data);
`ifdef MOD_ACC_RANGECHK_EN
      if (xv >= QL) begin
        xv    = xv - QL;
        m_err = 1;
      end
`endif
      m_sum = (m_sum + xv) % QL;
      m_cnt++;
      if (m_cnt == N) begin
        m_out  = m_sum;
        m_sum  = 0;
        m_cnt  = 0;
        m_hold = 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("in_ready",  longint'(in_ready),  longint'(!m_hold));
    chk("out_valid", longint'(out_valid), longint'(m_hold));
    chk("out_data",  longint'(out_data),  m_out);
    chk("err",       longint'(err),       longint'(m_err));
    chk("acc_lt_q",  longint'(longint'(dut.acc) < QL), 1);
  end

  task automatic beat(input logic [31:0] v);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Four beats then a literal check of the result one cycle after the last accept
  task automatic frame(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d, input longint exp);
    beat(a); beat(b); beat(c); beat(d);
    chk({name, "_valid"}, longint'(out_valid), 1);
    chk({name, "_data"},  longint'(out_data),  exp);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready",  longint'(in_ready),  1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data",  longint'(out_data),  0);
    chk("rst_err",       longint'(err),       0);
    @(negedge clk);

    frame("basic", 1, 2, 3, 4, 10);

    frame("qm1", 32'd4294955008, 32'd4294955008, 32'd4294955008, 32'd4294955008,
          64'd4294955005);

    // Backpressure: result held, input blocked, then a beat offered on the exit cycle is dropped
    out_ready = 1'b0;
    beat(10); beat(20); beat(30); beat(40);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'd999;
      chk("bp_valid", longint'(out_valid), 1);
      chk("bp_data",  longint'(out_data),  100);
      chk("bp_ready", longint'(in_ready),  0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_data   = 32'd50;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_release", longint'(in_ready), 1);
    frame("after_bp", 1, 2, 3, 4, 10);

    // clr in ACC beats a same-cycle beat
    beat(7); beat(9);
    clr = 1'b1; in_valid = 1'b1; in_data = 32'd100;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    frame("clr_acc", 5, 5, 5, 5, 20);

    // clr in HOLD abandons the result but keeps out_data
    out_ready = 1'b0;
    beat(2); beat(2); beat(2); beat(2);
    chk("hold_pre_clr", longint'(out_valid), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; out_ready = 1'b1;
    chk("clr_hold_valid", longint'(out_valid), 0);
    chk("clr_hold_data",  longint'(out_data),  8);
    frame("after_clr_hold", 3, 3, 3, 3, 12);

    // Mid-frame reset
    beat(1000); beat(1000); beat(1000);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_data",  longint'(out_data),  0);
    chk("mid_rst_ready", longint'(in_ready),  1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame("after_rst", 1, 1, 1, 1, 4);

`ifdef MOD_ACC_RANGECHK_EN
    frame("rangechk", 32'd4294955012, 1, 1, 1, 6);
    chk("err_set", longint'(err), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("err_after_clr", longint'(err), 1);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
